segre_icache_refill: RTL
========================

SEGRE_ICACHE_REFILL -- requirements
Module: segre_icache_refill

Interface
REQ-001 Parameters SHALL be, one per line:
  - WORD_SIZE, 32, memory beat width.
  - ADDR_SIZE, 32, address width.
  - ICACHE_LANE_SIZE, 128, cache line width.
  - ICACHE_INDEX_SIZE, 2, line index width (4 lines).
  - ICACHE_BYTE_SIZE, 4, line byte-offset width.
REQ-002 Ports SHALL be, one per line:
  - clk_i  in  1  clock; single clock domain, all state on rising edge.
  - rst_i  in  1  reset; asynchronous, active-high.
  - ic_access_i  in  1  fetch-stage tag lookup this cycle.
  - ic_miss_i  in  1  lookup missed.
  - ic_addr_i  in  ADDR_SIZE  miss: fetch PC; hit: zero-extended hit index.
  - mmu_data_o  out  1  one-cycle pulse; line valid for write.
  - mmu_wr_data_o  out  ICACHE_LANE_SIZE  assembled line.
  - mmu_lru_index_o  out  ICACHE_INDEX_SIZE  line slot to fill.
  - mem_rd_o  out  1  memory read request.
  - mem_addr_o  out  ADDR_SIZE  word-aligned read address.
  - mem_ready_i  in  1  memory data valid; handshake completes.
  - mem_data_i  in  WORD_SIZE  read data.
  - refill_cnt_o  out  32  completed refills, saturating.

Function
REQ-003 FSM SHALL have states RF_IDLE, RF_FETCH and RF_DONE.
REQ-004 RF_IDLE: on ic_access_i && ic_miss_i, SHALL latch line_addr = {ic_addr_i[ADDR_SIZE-1:ICACHE_BYTE_SIZE], 0}, latch victim index, clear beat counter and go to RF_FETCH next cycle.
REQ-005 RF_FETCH: mem_rd_o=1; mem_addr_o = line_addr + 4*beat; address SHALL stay stable until mem_ready_i.
REQ-006 Beat accept: on mem_rd_o && mem_ready_i, mem_data_i SHALL be stored at mmu_wr_data_o[32*beat+31:32*beat] and beat SHALL increment.
REQ-007 Acceptance of beat 3 SHALL move the FSM to RF_DONE. The beat counter wraps 3->0 and no fifth request is issued.
REQ-008 RF_DONE: mmu_data_o=1 for exactly one cycle, refill_cnt_o increments (holds at 0xFFFFFFFF), then RF_IDLE.
REQ-009 Latency with mem_ready_i tied high: miss sampled at edge N -> RF_FETCH cycles N+1..N+4 -> mmu_data_o high in cycle N+5.
REQ-010 ic_access_i/ic_miss_i in RF_FETCH or RF_DONE SHALL be ignored: no second capture and no LRU change.
REQ-011 LRU SHALL keep a 2-bit age per line; victim = line with age 3. Ages SHALL always be a permutation of 0..3.
REQ-012 Touch of line i SHALL increment every age < age[i] and set age[i]=0.
REQ-013 A touch SHALL occur on a hit in RF_IDLE (ic_access_i && !ic_miss_i, i = ic_addr_i[1:0]) and in RF_DONE (i = latched victim).
REQ-014 A hit and a miss in the same cycle is impossible; if both are asserted, the miss wins.
REQ-015 mmu_lru_index_o SHALL be the live victim in RF_IDLE, and the latched victim from capture through RF_DONE inclusive.
REQ-016 mmu_wr_data_o SHALL hold its value after RF_DONE until the next beat is written.
REQ-017 mem_ready_i outside RF_FETCH SHALL be ignored.

Reset
REQ-018 rst_i SHALL act immediately, independent of clk_i: FSM=RF_IDLE, beat=0, mmu_data_o=0, mem_rd_o=0, mem_addr_o=0, mmu_wr_data_o=0, refill_cnt_o=0, ages[0..3]={0,1,2,3}, mmu_lru_index_o=3.
REQ-019 Reset during RF_FETCH or RF_DONE SHALL abort the refill with no mmu_data_o pulse and no counter or LRU update.

Verification
REQ-020 Zero-wait refill: miss at PC 0x0000_1234, memory returns 0x11,0x22,0x33,0x44 -> addresses 0x1230,0x1234,0x1238,0x123C; pulse at N+5; mmu_wr_data_o=0x00000044_00000033_00000022_00000011; mmu_lru_index_o=3; refill_cnt_o=1.
REQ-021 Wait states: mem_ready_i low 3 cycles before each beat -> mem_addr_o stable while waiting; pulse at N+17; single pulse.
REQ-022 LRU: after reset, hits on indices 3, 2, 1 -> victim 0. A following miss fills slot 0 -> victim becomes 3.
REQ-023 Ignored events: second miss and a hit asserted during RF_FETCH -> no recapture, ages unchanged, addresses still from the first line.
REQ-024 Reset mid-op: rst_i pulsed after beat 2 -> mem_rd_o drops asynchronously; no pulse; refill_cnt_o=0; victim=3; a new miss restarts at beat 0.

Source files
------------

// File: rtl/segre_icache_refill.sv
// rtl/segre_icache_refill.sv - instruction cache line refill engine with LRU victim tracking
//
// Purpose:
//   On a fetch-stage miss, reads one cache line from memory as four word beats
//   and presents the assembled line for one cycle so the cache can write it
//   into the LRU victim slot. A per-line age table selects the victim.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   ic_access_i           tag lookup performed this cycle
//   ic_miss_i             the lookup missed
//   ic_addr_i             miss: fetch PC; hit: zero-extended hit index
//   mmu_data_o            one-cycle pulse, assembled line is valid
//   mmu_wr_data_o         assembled line
//   mmu_lru_index_o       line slot to fill
//   mem_rd_o              memory read request
//   mem_addr_o            word-aligned read address
//   mem_ready_i           memory data valid, completes the beat
//   mem_data_i            memory read data
//   refill_cnt_o          completed refills, saturating
module segre_icache_refill #(
  parameter int WORD_SIZE         = 32,
  parameter int ADDR_SIZE         = 32,
  parameter int ICACHE_LANE_SIZE  = 128,
  parameter int ICACHE_INDEX_SIZE = 2,
  parameter int ICACHE_BYTE_SIZE  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ic_access_i,
  input  logic                         ic_miss_i,
  input  logic [ADDR_SIZE-1:0]         ic_addr_i,
  output logic                         mmu_data_o,
  output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
  output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
  output logic                         mem_rd_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_ready_i,
  input  logic [WORD_SIZE-1:0]         mem_data_i,
  output logic [31:0]                  refill_cnt_o
);

  localparam int LINES      = 1 << ICACHE_INDEX_SIZE;
  localparam int BEATS      = ICACHE_LANE_SIZE / WORD_SIZE;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int BYTE_SHIFT = $clog2(WORD_SIZE / 8);

  localparam logic [ICACHE_INDEX_SIZE-1:0] AGE_OLDEST = '1;
  localparam logic [BEAT_W-1:0]            LAST_BEAT  = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_FETCH = 2'd1,
    RF_DONE  = 2'd2
  } rf_state_t;

  rf_state_t r_state;
  rf_state_t w_next_state;

  logic [BEAT_W-1:0]            r_beat;
  logic [ADDR_SIZE-1:0]         r_line_addr;
  logic [ICACHE_INDEX_SIZE-1:0] r_victim;
  logic [ICACHE_INDEX_SIZE-1:0] r_age [LINES];
  logic [ICACHE_LANE_SIZE-1:0]  r_wr_data;
  logic [31:0]                  r_cnt;

  logic                         w_miss;
  logic                         w_capture;
  logic                         w_hit;
  logic                         w_beat_acc;
  logic                         w_touch_en;
  logic [ICACHE_INDEX_SIZE-1:0] w_touch_idx;
  logic [ICACHE_INDEX_SIZE-1:0] w_touch_age;
  logic [ICACHE_INDEX_SIZE-1:0] w_live_victim;
  logic [ADDR_SIZE-1:0]         w_beat_offset;

  // Only the hit index bits and the line-address bits of ic_addr_i matter;
  // the word-offset bits in between are deliberately dropped.
  logic w_unused;
  assign w_unused = ^ic_addr_i[ICACHE_BYTE_SIZE-1:ICACHE_INDEX_SIZE];

  // Request qualification. A miss takes priority over a hit, and lookups
  // are only honoured while idle.
  assign w_miss      = ic_access_i && ic_miss_i;
  assign w_capture   = (r_state == RF_IDLE) && w_miss;
  assign w_hit       = (r_state == RF_IDLE) && ic_access_i && !ic_miss_i;
  assign w_beat_acc  = (r_state == RF_FETCH) && mem_ready_i;

  // The filled line counts as most recently used once it is handed over.
  assign w_touch_en  = w_hit || (r_state == RF_DONE);
  assign w_touch_idx = (r_state == RF_DONE) ? r_victim
                                            : ic_addr_i[ICACHE_INDEX_SIZE-1:0];
  assign w_touch_age = r_age[w_touch_idx];

  assign w_beat_offset = ADDR_SIZE'(r_beat) << BYTE_SHIFT;

  // Ages form a permutation, so exactly one line carries the oldest age.
  always_comb begin
    w_live_victim = '0;
    for (int i = 0; i < LINES; i++) begin
      if (r_age[i] == AGE_OLDEST) begin
        w_live_victim = ICACHE_INDEX_SIZE'(i);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RF_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RF_IDLE: begin
        if (w_miss) begin
          w_next_state = RF_FETCH;
        end
      end
      RF_FETCH: begin
        if (mem_ready_i && (r_beat == LAST_BEAT)) begin
          w_next_state = RF_DONE;
        end
      end
      RF_DONE: begin
        w_next_state = RF_IDLE;
      end
      default: begin
        w_next_state = RF_IDLE;
      end
    endcase
  end

  // FSM: outputs. Decoding straight from the state register lets the
  // asynchronous reset pull mem_rd_o and mem_addr_o low immediately.
  always_comb begin
    mem_rd_o        = 1'b0;
    mem_addr_o      = '0;
    mmu_data_o      = 1'b0;
    mmu_lru_index_o = r_victim;
    case (r_state)
      RF_IDLE: begin
        mmu_lru_index_o = w_live_victim;
      end
      RF_FETCH: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = r_line_addr + w_beat_offset;
      end
      RF_DONE: begin
        mmu_data_o = 1'b1;
      end
      default: begin
        mmu_lru_index_o = r_victim;
      end
    endcase
  end

  // Refill datapath: line address, victim slot, beat counter, line buffer
  // and completion counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beat      <= '0;
      r_line_addr <= '0;
      r_victim    <= '1;
      r_wr_data   <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_capture) begin
        r_line_addr <= {ic_addr_i[ADDR_SIZE-1:ICACHE_BYTE_SIZE], {ICACHE_BYTE_SIZE{1'b0}}};
        r_victim    <= w_live_victim;
        r_beat      <= '0;
      end
      if (w_beat_acc) begin
        // Counter wraps back to zero after the last beat.
        r_beat <= r_beat + BEAT_W'(1);
        for (int b = 0; b < BEATS; b++) begin
          if (r_beat == BEAT_W'(b)) begin
            r_wr_data[b*WORD_SIZE +: WORD_SIZE] <= mem_data_i;
          end
        end
      end
      if ((r_state == RF_DONE) && (r_cnt != 32'hFFFF_FFFF)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  // LRU ages: a touched line becomes youngest and every line younger than
  // it ages by one, which keeps the ages a permutation of 0..LINES-1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < LINES; j++) begin
        r_age[j] <= ICACHE_INDEX_SIZE'(j);
      end
    end else if (w_touch_en) begin
      for (int j = 0; j < LINES; j++) begin
        if (ICACHE_INDEX_SIZE'(j) == w_touch_idx) begin
          r_age[j] <= '0;
        end else if (r_age[j] < w_touch_age) begin
          r_age[j] <= r_age[j] + ICACHE_INDEX_SIZE'(1);
        end
      end
    end
  end

  assign mmu_wr_data_o = r_wr_data;
  assign refill_cnt_o  = r_cnt;

endmodule
